aes_round_arbiter: RTL and testbench

Arbiter and sequencer for the shared multi-round AES engine: it accepts 128-bit block requests from two clients, picks one round-robin and maps the key size to a round count. It drives the engine's parameter, data and last-round-done inputs, collects the result and returns it on a response channel. It sits between the HPS/DMA-facing request logic and the multi-round engine instance, and is the only driver of that engine's control inputs.

---
 rtl/aes_round_arbiter.sv | 166 ++++++++++++++++
 tb/tb_aes_round_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_arbiter.sv
// Round-robin arbiter and sequencer in front of the shared multi-round AES engine.
// Optional BUSY watchdog enabled by defining AES_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module aes_round_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic         iReq0_valid,
    output logic         oReq0_ready,
    input  logic         iReq0_endec,
    input  logic [3:0]   iReq0_size,
    input  logic [127:0] iReq0_data,
    input  logic         iReq1_valid,
    output logic         oReq1_ready,
    input  logic         iReq1_endec,
    input  logic [3:0]   iReq1_size,
    input  logic [127:0] iReq1_data,
    output logic         oRsp_valid,
    input  logic         iRsp_ready,
    output logic         oRsp_id,
    output logic         oRsp_error,
    output logic [127:0] oRsp_data,
    output logic         oEng_endec,
    output logic [3:0]   oEng_round,
    output logic [3:0]   oEng_size,
    output logic         oEng_data_valid,
    output logic [31:0]  oEng_data_1,
    output logic [31:0]  oEng_data_2,
    output logic [31:0]  oEng_data_3,
    output logic [31:0]  oEng_data_4,
    input  logic         iEng_data_valid,
    input  logic [31:0]  iEng_data_1,
    input  logic [31:0]  iEng_data_2,
    input  logic [31:0]  iEng_data_3,
    input  logic [31:0]  iEng_data_4,
    output logic         oEng_last_round_done
);

    // state | meaning
    // IDLE  | waiting for a request; grant offered combinationally
    // ISSUE | start strobe to the engine with the latched block
    // BUSY  | waiting for the engine result (or watchdog)
    // LAST  | last-round-done pulse to reset the engine RAM address
    // RESP  | response held until the consumer takes it
    typedef enum logic [2:0] {IDLE, ISSUE, BUSY, LAST, RESP} arbState_t;

    arbState_t     state;
    arbState_t     stateNext;
    logic          prioPtr;
    logic          grant0;
    logic          grant1;
    logic          accept;
    logic          selEndec;
    logic [3:0]    selSize;
    logic [127:0]  selData;
    logic [3:0]    selRound;
    logic          sizeOk;
    logic          tmoHit;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : gBadTimeout
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

`ifdef AES_ARB_TIMEOUT_EN
    logic [7:0] tmoCnt;

    // Counts completed BUSY cycles; held at zero everywhere else.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            tmoCnt <= 8'd0;
        end else if (state != BUSY) begin
            tmoCnt <= 8'd0;
        end else begin
            tmoCnt <= tmoCnt + 8'd1;
        end
    end

    assign tmoHit = (tmoCnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign tmoHit = 1'b0;
`endif

    always_comb begin
        grant0   = iReq0_valid & (~iReq1_valid | ~prioPtr);
        grant1   = iReq1_valid & (~iReq0_valid |  prioPtr);
        selEndec = grant1 ? iReq1_endec : iReq0_endec;
        selSize  = grant1 ? iReq1_size  : iReq0_size;
        selData  = grant1 ? iReq1_data  : iReq0_data;
        selRound = 4'd0;
        sizeOk   = 1'b1;
        case (selSize)
            4'd4:    selRound = 4'd10;
            4'd6:    selRound = 4'd12;
            4'd8:    selRound = 4'd14;
            default: sizeOk   = 1'b0;
        endcase
    end

    assign oReq0_ready          = (state == IDLE) & grant0;
    assign oReq1_ready          = (state == IDLE) & grant1;
    assign accept               = oReq0_ready | oReq1_ready;
    assign oEng_data_valid      = (state == ISSUE);
    assign oEng_last_round_done = (state == LAST);
    assign oRsp_valid           = (state == RESP);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = sizeOk ? ISSUE : RESP;
            ISSUE:   stateNext = BUSY;
            BUSY:    if (iEng_data_valid || tmoHit) stateNext = LAST;
            LAST:    stateNext = RESP;
            RESP:    if (iRsp_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state       <= IDLE;
            prioPtr     <= 1'b0;
            oRsp_id     <= 1'b0;
            oRsp_error  <= 1'b0;
            oRsp_data   <= '0;
            oEng_endec  <= 1'b0;
            oEng_round  <= 4'd0;
            oEng_size   <= 4'd0;
            oEng_data_1 <= '0;
            oEng_data_2 <= '0;
            oEng_data_3 <= '0;
            oEng_data_4 <= '0;
        end else begin
            state <= stateNext;
            if (accept) begin
                oRsp_id <= grant1;
                if (sizeOk) begin
                    oEng_endec  <= selEndec;
                    oEng_round  <= selRound;
                    oEng_size   <= selSize;
                    oEng_data_1 <= selData[127:96];
                    oEng_data_2 <= selData[95:64];
                    oEng_data_3 <= selData[63:32];
                    oEng_data_4 <= selData[31:0];
                end else begin
                    oRsp_error <= 1'b1;
                    oRsp_data  <= '0;
                end
            end
            // A result arriving on the watchdog's last cycle takes precedence.
            if (state == BUSY) begin
                if (iEng_data_valid) begin
                    oRsp_error <= 1'b0;
                    oRsp_data  <= {iEng_data_1, iEng_data_2, iEng_data_3, iEng_data_4};
                end else if (tmoHit) begin
                    oRsp_error <= 1'b1;
                    oRsp_data  <= '0;
                end
            end
            if (state == RESP && iRsp_ready) begin
                prioPtr <= ~oRsp_id;
            end
        end
    end

endmodule

// File: tb/tb_aes_round_arbiter.sv
// Randomized self-checking bench for aes_round_arbiter against a transaction-level model.
`timescale 1ns/1ps
module tb_aes_round_arbiter;

    localparam int TMO = 20;

    logic         iClk = 1'b0;
    logic         iRst_n = 1'b0;
    logic         reqValid [2];
    logic         reqEndec [2];
    logic [3:0]   reqSize  [2];
    logic [127:0] reqData  [2];
    logic         oReq0_ready, oReq1_ready;
    logic         oRsp_valid, oRsp_id, oRsp_error;
    logic         iRsp_ready;
    logic [127:0] oRsp_data;
    logic         oEng_endec, oEng_data_valid, oEng_last_round_done;
    logic [3:0]   oEng_round, oEng_size;
    logic [31:0]  oEng_data_1, oEng_data_2, oEng_data_3, oEng_data_4;
    logic         iEng_data_valid;
    logic [127:0] engWord;

    int   nCmp = 0;
    int   nBad = 0;
    logic modelPtr = 1'b0;

    always #5 iClk = ~iClk;

    aes_round_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .iClk                 (iClk),
        .iRst_n               (iRst_n),
        .iReq0_valid          (reqValid[0]),
        .oReq0_ready          (oReq0_ready),
        .iReq0_endec          (reqEndec[0]),
        .iReq0_size           (reqSize[0]),
        .iReq0_data           (reqData[0]),
        .iReq1_valid          (reqValid[1]),
        .oReq1_ready          (oReq1_ready),
        .iReq1_endec          (reqEndec[1]),
        .iReq1_size           (reqSize[1]),
        .iReq1_data           (reqData[1]),
        .oRsp_valid           (oRsp_valid),
        .iRsp_ready           (iRsp_ready),
        .oRsp_id              (oRsp_id),
        .oRsp_error           (oRsp_error),
        .oRsp_data            (oRsp_data),
        .oEng_endec           (oEng_endec),
        .oEng_round           (oEng_round),
        .oEng_size            (oEng_size),
        .oEng_data_valid      (oEng_data_valid),
        .oEng_data_1          (oEng_data_1),
        .oEng_data_2          (oEng_data_2),
        .oEng_data_3          (oEng_data_3),
        .oEng_data_4          (oEng_data_4),
        .iEng_data_valid      (iEng_data_valid),
        .iEng_data_1          (engWord[127:96]),
        .iEng_data_2          (engWord[95:64]),
        .iEng_data_3          (engWord[63:32]),
        .iEng_data_4          (engWord[31:0]),
        .oEng_last_round_done (oEng_last_round_done)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic newReq(input int c, input logic en, input logic [3:0] sz, input logic [127:0] d);
        reqValid[c] = 1'b1;
        reqEndec[c] = en;
        reqSize[c]  = sz;
        reqData[c]  = d;
    endtask

    // One full transaction from grant to response handshake, checked against the model.
    task automatic serve(input int delay, input logic [127:0] engRes, input int hold,
                         input bit silent, output int who);
        bit           found = 0;
        bit           good;
        logic         expGrant, en, expErr;
        logic [3:0]   sz;
        logic [127:0] d, expData;
        int           spurious = 0;
        who = 0;
        engWord = rnd128();
        for (int i = 0; i < 20 && !found; i++) begin
            #1;
            if (oReq0_ready || oReq1_ready) found = 1;
            else step();
        end
        chk("accept_seen", 128'(found), 128'(1));
        if (!found) return;
        expGrant = (reqValid[0] && reqValid[1]) ? modelPtr : reqValid[1];
        chk("grant", 128'({oReq1_ready, oReq0_ready}), expGrant ? 128'(2) : 128'(1));
        who  = int'(expGrant);
        en   = reqEndec[who];
        sz   = reqSize[who];
        d    = reqData[who];
        good = (sz == 4'd4) || (sz == 4'd6) || (sz == 4'd8);
        step();
        reqValid[who] = 1'b0;
        if (!good) begin
            expErr  = 1'b1;
            expData = '0;
            chk("bad_no_start", 128'(oEng_data_valid), 128'(0));
        end else begin
            chk("eng_start", 128'(oEng_data_valid), 128'(1));
            chk("eng_round", 128'(oEng_round), 128'(6 + int'(sz)));
            chk("eng_size", 128'(oEng_size), 128'(sz));
            chk("eng_endec", 128'(oEng_endec), 128'(en));
            chk("eng_words", {oEng_data_1, oEng_data_2, oEng_data_3, oEng_data_4}, d);
            step();
            chk("eng_start_once", 128'(oEng_data_valid), 128'(0));
            for (int t = 0; t < delay; t++) begin
                spurious += int'(oEng_last_round_done) + int'(oRsp_valid) + int'(oEng_data_valid);
                step();
            end
            if (!silent) begin
                iEng_data_valid = 1'b1;
                engWord = engRes;
                step();
                iEng_data_valid = 1'b0;
                engWord = rnd128();
                expErr  = 1'b0;
                expData = engRes;
            end else begin
                expErr  = 1'b1;
                expData = '0;
            end
            chk("busy_quiet", 128'(spurious), 128'(0));
            chk("last_done", 128'(oEng_last_round_done), 128'(1));
            chk("rsp_early", 128'(oRsp_valid), 128'(0));
            step();
            chk("last_done_once", 128'(oEng_last_round_done), 128'(0));
        end
        chk("rsp_valid", 128'(oRsp_valid), 128'(1));
        chk("rsp_id", 128'(oRsp_id), 128'(expGrant));
        chk("rsp_error", 128'(oRsp_error), 128'(expErr));
        chk("rsp_data", oRsp_data, expData);
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_ctl", 128'({oRsp_valid, oRsp_id, oRsp_error}), 128'({1'b1, expGrant, expErr}));
            chk("hold_data", oRsp_data, expData);
        end
        iRsp_ready = 1'b1;
        step();
        iRsp_ready = 1'b0;
        chk("rsp_done", 128'(oRsp_valid), 128'(0));
        modelPtr = ~expGrant;
    endtask

    initial begin
        int who;
        int cnt;
        int busyWait;
        for (int c = 0; c < 2; c++) begin
            reqValid[c] = 1'b0;
            reqEndec[c] = 1'b0;
            reqSize[c]  = 4'd0;
            reqData[c]  = '0;
        end
        iRsp_ready      = 1'b0;
        iEng_data_valid = 1'b0;
        engWord         = '0;
        repeat (3) step();
        iRst_n = 1'b1;
        step();

        chk("rst_rsp_valid", 128'(oRsp_valid), 128'(0));
        chk("rst_rsp_meta", 128'({oRsp_id, oRsp_error}), 128'(0));
        chk("rst_rsp_data", oRsp_data, 128'(0));
        chk("rst_eng_ctl", 128'({oEng_endec, oEng_round, oEng_size}), 128'(0));
        chk("rst_eng_strobes", 128'({oEng_data_valid, oEng_last_round_done}), 128'(0));
        chk("rst_eng_words", {oEng_data_1, oEng_data_2, oEng_data_3, oEng_data_4}, 128'(0));
        chk("idle_ready", 128'({oReq1_ready, oReq0_ready}), 128'(0));

        // Both clients continuously valid: strict alternation starting at client 0.
        newReq(0, 1'b1, 4'd4, rnd128());
        newReq(1, 1'b0, 4'd8, rnd128());
        for (int i = 0; i < 4; i++) begin
            serve(int'($urandom_range(0, 4)), rnd128(), 0, 0, who);
            chk("alternate", 128'(who), 128'(i % 2));
            newReq(who, 1'($urandom_range(0, 1)), 4'd6, rnd128());
        end
        reqValid[0] = 1'b0;
        reqValid[1] = 1'b0;
        step();

        // FIPS-197 AES-128 example block.
        newReq(0, 1'b1, 4'd4, 128'h00112233445566778899aabbccddeeff);
        serve(3, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 0, who);

        // Unsupported key size, with the response held off for 10 cycles.
        newReq(1, 1'b1, 4'd5, rnd128());
        serve(0, '0, 10, 0, who);

`ifdef AES_ARB_TIMEOUT_EN
        newReq(0, 1'b0, 4'd6, rnd128());
        serve(TMO, '0, 2, 1, who);
        busyWait = 5;
`else
        busyWait = 1100;
`endif

        // Silent engine, then reset while BUSY.
        newReq(0, 1'b1, 4'd8, rnd128());
        #1;
        chk("rb_accept", 128'(oReq0_ready), 128'(1));
        step();
        reqValid[0] = 1'b0;
        chk("rb_start", 128'(oEng_data_valid), 128'(1));
        step();
        cnt = 0;
        for (int t = 0; t < busyWait; t++) begin
            cnt += int'(oEng_last_round_done) + int'(oRsp_valid);
            step();
        end
        chk("rb_busy_wait", 128'(cnt), 128'(0));
        iRst_n = 1'b0;
        step();
        iRst_n = 1'b1;
        chk("rb_rsp_valid", 128'(oRsp_valid), 128'(0));
        chk("rb_strobes", 128'({oEng_data_valid, oEng_last_round_done}), 128'(0));
        chk("rb_rsp_data", oRsp_data, 128'(0));
        iEng_data_valid = 1'b1;
        step();
        iEng_data_valid = 1'b0;
        cnt = 0;
        for (int t = 0; t < 6; t++) begin
            cnt += int'(oRsp_valid) + int'(oEng_last_round_done) + int'(oEng_data_valid);
            step();
        end
        chk("rb_stray_ignored", 128'(cnt), 128'(0));
        modelPtr = 1'b0;

        // Randomized traffic; pending requests stay valid until granted.
        for (int n = 0; n < 40; n++) begin
            for (int c = 0; c < 2; c++) begin
                if (!reqValid[c] && $urandom_range(0, 1) == 1) begin
                    int sel = int'($urandom_range(0, 6));
                    logic [3:0] sz = (sel < 6) ? 4'(4 + 2 * (sel % 3)) : 4'($urandom_range(0, 15));
                    newReq(c, 1'($urandom_range(0, 1)), sz, rnd128());
                end
            end
            if (!reqValid[0] && !reqValid[1]) begin
                newReq(int'($urandom_range(0, 1)), 1'b0, 4'd4, rnd128());
            end
            serve(int'($urandom_range(0, 6)), rnd128(), int'($urandom_range(0, 3)), 0, who);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
